// File: rtl/ocp_wait_memory.sv
// Behavioural OCP slave memory with configurable width/depth/base and independent read/write wait states.
// Optional address range check enabled by defining OCP_MEMORY_ADDR_CHECK_EN.
module ocp_wait_memory #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    READ_WS    = 0,
    parameter int                    WRITE_WS   = 0,
    localparam int                   BEN_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_MAddr,
    input  logic [2:0]            i_MCmd,
    input  logic [DATA_WIDTH-1:0] i_MData,
    input  logic [BEN_WIDTH-1:0]  i_MByteEn,
    output logic                  o_SCmdAccept,
    output logic [DATA_WIDTH-1:0] o_SData,
    output logic [1:0]            o_SResp
);

    localparam int OFFS  = $clog2(BEN_WIDTH);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd2;

    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
    localparam logic [7:0]            RWS     = 8'(READ_WS);
    localparam logic [7:0]            WWS     = 8'(WRITE_WS);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]            state_q, state_d;
    logic                  accept_q, accept_d;
    logic [1:0]            resp_q, resp_d;
    logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BEN_WIDTH-1:0]  ben_q, ben_d;
    logic                  oor_q, oor_d;

    logic                  accept_now;
    logic [7:0]            in_ws;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      in_idx;
    logic                  in_oor;
    logic                  fire;
    logic                  mem_we;
    logic [2:0]            acc_cmd;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [BEN_WIDTH-1:0]  acc_ben;
    logic                  acc_oor;

    always_comb begin
        offset = i_MAddr - BASE_ADDR;
        in_idx = IDX_W'((offset >> OFFS) % DEPTH_A);
`ifdef OCP_MEMORY_ADDR_CHECK_EN
        in_oor = (i_MAddr < BASE_ADDR) || (offset >= ADDR_WIDTH'(DEPTH * BEN_WIDTH));
`else
        in_oor = 1'b0;
`endif
        accept_now = accept_q && (i_MCmd != CMD_IDLE);
        case (i_MCmd)
            CMD_READ:  in_ws = RWS;
            CMD_WRITE: in_ws = WWS;
            default:   in_ws = 8'd0;
        endcase
    end

    // A zero-wait command is performed on its own accept edge straight from the
    // bus; a delayed one uses the copy latched at accept.
    always_comb begin
        fire      = 1'b0;
        acc_cmd   = cmd_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_ben   = ben_q;
        acc_oor   = oor_q;
        if (accept_now && (in_ws == 8'd0)) begin
            fire      = 1'b1;
            acc_cmd   = i_MCmd;
            acc_idx   = in_idx;
            acc_wdata = i_MData;
            acc_ben   = i_MByteEn;
            acc_oor   = in_oor;
        end else if ((state_q == ST_WAIT) && (cnt_q == 8'd1)) begin
            fire = 1'b1;
        end
        mem_we = fire && (acc_cmd == CMD_WRITE) && !acc_oor;
    end

    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ben_d   = ben_q;
        oor_d   = oor_q;
        resp_d  = RESP_NULL;
        sdata_d = sdata_q;

        if (accept_now) begin
            cmd_d   = i_MCmd;
            idx_d   = in_idx;
            wdata_d = i_MData;
            ben_d   = i_MByteEn;
            oor_d   = in_oor;
            cnt_d   = in_ws;
            state_d = (in_ws == 8'd0) ? ST_RESP : ST_WAIT;
        end else if (state_q == ST_WAIT) begin
            if (cnt_q == 8'd1) begin
                state_d = ST_RESP;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = cnt_q - 8'd1;
            end
        end

        if (fire) begin
            if ((acc_cmd == CMD_READ) || (acc_cmd == CMD_WRITE)) begin
                if (acc_oor) begin
                    resp_d  = RESP_ERR;
                    sdata_d = '0;
                end else begin
                    resp_d = RESP_DVA;
                    if (acc_cmd == CMD_READ) begin
                        sdata_d = mem_q[acc_idx];
                    end
                end
            end else begin
                resp_d = RESP_ERR;
            end
        end

        accept_d = (state_d != ST_WAIT);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            accept_q <= 1'b0;
            resp_q   <= RESP_NULL;
            sdata_q  <= '0;
            cnt_q    <= '0;
            cmd_q    <= CMD_IDLE;
            idx_q    <= '0;
            wdata_q  <= '0;
            ben_q    <= '0;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            accept_q <= accept_d;
            resp_q   <= resp_d;
            sdata_q  <= sdata_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            ben_q    <= ben_d;
            oor_q    <= oor_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive nrst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BEN_WIDTH; b++) begin
                if (acc_ben[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_SCmdAccept = accept_q;
    assign o_SResp      = resp_q;
    assign o_SData      = sdata_q;

endmodule

// File: tb/tb_ocp_wait_memory.sv
// Directed self-checking bench for ocp_wait_memory: four instances cover
// zero-wait, mixed wait states, long wait with reset, and a small based memory.
`timescale 1ns/1ps
module tb_ocp_wait_memory;

    localparam logic [2:0] RD = 3'd2;
    localparam logic [2:0] WR = 3'd1;
    localparam logic [2:0] ID = 3'd0;
    localparam logic [1:0] R_NULL = 2'd0;
    localparam logic [1:0] R_DVA  = 2'd1;
    localparam logic [1:0] R_ERR  = 2'd3;

    logic             clk;
    logic [3:0]       nrst;
    logic [3:0][31:0] addr;
    logic [3:0][2:0]  cmd;
    logic [3:0][31:0] wdat;
    logic [3:0][3:0]  ben;
    logic [3:0]       acc;
    logic [3:0][31:0] sdata;
    logic [3:0][1:0]  resp;

    int total = 0;
    int bad   = 0;

    ocp_wait_memory u0 (
        .clk(clk), .nrst(nrst[0]), .i_MAddr(addr[0]), .i_MCmd(cmd[0]), .i_MData(wdat[0]),
        .i_MByteEn(ben[0]), .o_SCmdAccept(acc[0]), .o_SData(sdata[0]), .o_SResp(resp[0]));

    ocp_wait_memory #(.READ_WS(3), .WRITE_WS(1)) u1 (
        .clk(clk), .nrst(nrst[1]), .i_MAddr(addr[1]), .i_MCmd(cmd[1]), .i_MData(wdat[1]),
        .i_MByteEn(ben[1]), .o_SCmdAccept(acc[1]), .o_SData(sdata[1]), .o_SResp(resp[1]));

    ocp_wait_memory #(.READ_WS(4), .WRITE_WS(4)) u2 (
        .clk(clk), .nrst(nrst[2]), .i_MAddr(addr[2]), .i_MCmd(cmd[2]), .i_MData(wdat[2]),
        .i_MByteEn(ben[2]), .o_SCmdAccept(acc[2]), .o_SData(sdata[2]), .o_SResp(resp[2]));

    ocp_wait_memory #(.DEPTH(16), .BASE_ADDR(32'h1000)) u3 (
        .clk(clk), .nrst(nrst[3]), .i_MAddr(addr[3]), .i_MCmd(cmd[3]), .i_MData(wdat[3]),
        .i_MByteEn(ben[3]), .o_SCmdAccept(acc[3]), .o_SData(sdata[3]), .o_SResp(resp[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        cmd[k]  = c;
        addr[k] = a;
        wdat[k] = d;
        ben[k]  = b;
    endtask

    task automatic idle(input int k);
        put(k, ID, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic wait_resp(input int k, output int n);
        n = 0;
        while (resp[k] === R_NULL && n < 32) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (acc[k] !== 1'b0) begin bad++; $display("FAIL rst_acc[%0d]: got %b want 0", k, acc[k]); end
            total++;
            if (resp[k] !== R_NULL) begin bad++; $display("FAIL rst_resp[%0d]: got %0d want 0", k, resp[k]); end
            total++;
            if (sdata[k] !== 32'h0) begin bad++; $display("FAIL rst_sdata[%0d]: got %h want 0", k, sdata[k]); end
        end
        nrst = 4'hF;
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (acc[k] !== 1'b1) begin bad++; $display("FAIL post_rst_acc[%0d]: got %b want 1", k, acc[k]); end
        end
    endtask

    task automatic test_ws0_rw();
        put(0, WR, 32'h0, 32'hDEADBEEF, 4'hF);
        total++;
        if (acc[0] !== 1'b1) begin bad++; $display("FAIL ws0_accept: got %b want 1", acc[0]); end
        tick();
        total++;
        if (resp[0] !== R_DVA) begin bad++; $display("FAIL ws0_wr_dva: got %0d want 1", resp[0]); end
        put(0, RD, 32'h0, 32'h0, 4'h0);
        tick();
        total++;
        if (resp[0] !== R_DVA) begin bad++; $display("FAIL ws0_rd_dva: got %0d want 1", resp[0]); end
        total++;
        if (sdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL ws0_rd_data: got %h want deadbeef", sdata[0]); end
        idle(0);
        tick();
        total++;
        if (resp[0] !== R_NULL) begin bad++; $display("FAIL ws0_null: got %0d want 0", resp[0]); end
        put(0, WR, 32'h0, 32'hBEEFDEAD, 4'h3);
        tick();
        put(0, RD, 32'h0, 32'h0, 4'h0);
        tick();
        total++;
        if (sdata[0] !== 32'hDEADDEAD) begin bad++; $display("FAIL ws0_ben: got %h want deaddead", sdata[0]); end
        idle(0);
        tick();
    endtask

    task automatic test_wait_states();
        int n;
        put(1, WR, 32'h4, 32'h0BADF00D, 4'hF);
        tick();
        idle(1);
        total++;
        if (acc[1] !== 1'b0 || resp[1] !== R_NULL) begin
            bad++; $display("FAIL wws_wait: got acc=%b resp=%0d want acc=0 resp=0", acc[1], resp[1]);
        end
        tick();
        total++;
        if (acc[1] !== 1'b1 || resp[1] !== R_DVA) begin
            bad++; $display("FAIL wws_resp: got acc=%b resp=%0d want acc=1 resp=1", acc[1], resp[1]);
        end
        tick();
        put(1, RD, 32'h4, 32'h0, 4'h0);
        tick();
        idle(1);
        n = 0;
        while (acc[1] === 1'b0 && n < 20) begin
            total++;
            if (resp[1] !== R_NULL) begin bad++; $display("FAIL rws_early_resp: got %0d want 0", resp[1]); end
            tick();
            n++;
        end
        total++;
        if (n != 3) begin bad++; $display("FAIL rws_low_cycles: got %0d want 3", n); end
        total++;
        if (resp[1] !== R_DVA || sdata[1] !== 32'h0BADF00D) begin
            bad++; $display("FAIL rws_data: got resp=%0d data=%h want 1 0badf00d", resp[1], sdata[1]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        put(0, WR, 32'hC, 32'hCAFEF00D, 4'hF);
        tick();
        idle(0);
        tick();
        put(0, WR, 32'h8, 32'h12345678, 4'hF);
        tick();
        total++;
        if (resp[0] !== R_DVA) begin bad++; $display("FAIL b2b_wr: got %0d want 1", resp[0]); end
        put(0, RD, 32'h8, 32'h0, 4'h0);
        tick();
        total++;
        if (resp[0] !== R_DVA || sdata[0] !== 32'h12345678 || acc[0] !== 1'b1) begin
            bad++; $display("FAIL b2b_rd8: got resp=%0d data=%h acc=%b want 1 12345678 1", resp[0], sdata[0], acc[0]);
        end
        put(0, RD, 32'hC, 32'h0, 4'h0);
        tick();
        total++;
        if (resp[0] !== R_DVA || sdata[0] !== 32'hCAFEF00D) begin
            bad++; $display("FAIL b2b_rdC: got resp=%0d data=%h want 1 cafef00d", resp[0], sdata[0]);
        end
        idle(0);
        tick();
        total++;
        if (resp[0] !== R_NULL || sdata[0] !== 32'hCAFEF00D) begin
            bad++; $display("FAIL b2b_hold: got resp=%0d data=%h want 0 cafef00d", resp[0], sdata[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        put(2, WR, 32'h10, 32'hA5A5A5A5, 4'hF);
        tick();
        idle(2);
        wait_resp(2, n);
        total++;
        if (n != 4 || resp[2] !== R_DVA) begin
            bad++; $display("FAIL ws4_wr_latency: got n=%0d resp=%0d want 4 1", n, resp[2]);
        end
        tick();
        put(2, RD, 32'h10, 32'h0, 4'h0);
        tick();
        idle(2);
        wait_resp(2, n);
        total++;
        if (sdata[2] !== 32'hA5A5A5A5) begin bad++; $display("FAIL ws4_rd: got %h want a5a5a5a5", sdata[2]); end
        tick();
        put(2, WR, 32'h10, 32'h11111111, 4'hF);
        tick();
        idle(2);
        tick();
        tick();
        nrst[2] = 1'b0;
        #1;
        total++;
        if (acc[2] !== 1'b0 || resp[2] !== R_NULL || sdata[2] !== 32'h0) begin
            bad++; $display("FAIL midrst_outputs: got acc=%b resp=%0d data=%h want 0 0 0", acc[2], resp[2], sdata[2]);
        end
        tick();
        tick();
        nrst[2] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp[2] !== R_NULL) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL midrst_no_resp: got response=1 want 0"); end
        put(2, RD, 32'h10, 32'h0, 4'h0);
        tick();
        idle(2);
        wait_resp(2, n);
        total++;
        if (resp[2] !== R_DVA || sdata[2] !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL midrst_mem: got resp=%0d data=%h want 1 a5a5a5a5", resp[2], sdata[2]);
        end
        tick();
    endtask

    task automatic test_illegal();
        put(0, WR, 32'h20, 32'h55AA55AA, 4'hF);
        tick();
        put(0, RD, 32'h20, 32'h0, 4'h0);
        tick();
        idle(0);
        tick();
        put(0, 3'd3, 32'h20, 32'hFFFFFFFF, 4'hF);
        total++;
        if (acc[0] !== 1'b1) begin bad++; $display("FAIL ill_accept: got %b want 1", acc[0]); end
        tick();
        total++;
        if (resp[0] !== R_ERR) begin bad++; $display("FAIL ill_err: got %0d want 3", resp[0]); end
        idle(0);
        tick();
        total++;
        if (resp[0] !== R_NULL || sdata[0] !== 32'h55AA55AA) begin
            bad++; $display("FAIL ill_after: got resp=%0d data=%h want 0 55aa55aa", resp[0], sdata[0]);
        end
        put(0, RD, 32'h20, 32'h0, 4'h0);
        tick();
        total++;
        if (sdata[0] !== 32'h55AA55AA) begin bad++; $display("FAIL ill_mem: got %h want 55aa55aa", sdata[0]); end
        idle(0);
        tick();
    endtask

    task automatic test_addr_check();
        logic [1:0]  exp_resp;
        logic [31:0] exp_rd40;
        logic [31:0] exp_w15;
`ifdef OCP_MEMORY_ADDR_CHECK_EN
        exp_resp = R_ERR;
        exp_rd40 = 32'h0;
        exp_w15  = 32'h12121212;
`else
        exp_resp = R_DVA;
        exp_rd40 = 32'h77777777;
        exp_w15  = 32'h99999999;
`endif
        put(3, WR, 32'h1000, 32'h77777777, 4'hF);
        tick();
        put(3, WR, 32'h103C, 32'h12121212, 4'hF);
        tick();
        put(3, RD, 32'h1000, 32'h0, 4'h0);
        tick();
        total++;
        if (sdata[3] !== 32'h77777777) begin bad++; $display("FAIL ac_base: got %h want 77777777", sdata[3]); end
        put(3, RD, 32'h1040, 32'h0, 4'h0);
        tick();
        total++;
        if (resp[3] !== exp_resp || sdata[3] !== exp_rd40) begin
            bad++; $display("FAIL ac_rd_over: got resp=%0d data=%h want %0d %h", resp[3], sdata[3], exp_resp, exp_rd40);
        end
        put(3, WR, 32'h0FFC, 32'h99999999, 4'hF);
        tick();
        total++;
        if (resp[3] !== exp_resp) begin bad++; $display("FAIL ac_wr_under: got %0d want %0d", resp[3], exp_resp); end
        put(3, RD, 32'h103C, 32'h0, 4'h0);
        tick();
        total++;
        if (resp[3] !== R_DVA || sdata[3] !== exp_w15) begin
            bad++; $display("FAIL ac_word15: got resp=%0d data=%h want 1 %h", resp[3], sdata[3], exp_w15);
        end
        idle(3);
        tick();
    endtask

    initial begin
        nrst = 4'h0;
        for (int k = 0; k < 4; k++) idle(k);
        tick();
        tick();
        test_reset();
        test_ws0_rw();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        test_addr_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
